// File: rtl/vend_ctrl_if.sv
// Vending controller I/O bundle: pulse/level inputs and registered status outputs.
interface vend_ctrl_if;
   logic       i_coin_n;
   logic       i_sel_n;
   logic       i_cancel_n;
   logic       i_empty;
   logic [3:0] o_credit;
   logic       o_dispense;
   logic       o_refund;
   logic       o_reject;
   logic       o_busy;

   modport slave (
      input  i_coin_n, i_sel_n, i_cancel_n, i_empty,
      output o_credit, o_dispense, o_refund, o_reject, o_busy
   );

   modport master (
      output i_coin_n, i_sel_n, i_cancel_n, i_empty,
      input  o_credit, o_dispense, o_refund, o_reject, o_busy
   );
endinterface

// File: rtl/vend_ctrl.sv
// Coin-credit vending controller: accumulates credit, dispenses on select,
// refunds remaining credit one unit per cycle. All outputs are registered.
module vend_ctrl #(
   parameter int unsigned PRICE       = 3,
   parameter int unsigned MAX_CREDIT  = 9,
   parameter int unsigned DISP_CYCLES = 4
) (
   input logic        i_clk,
   input logic        i_rst,
   vend_ctrl_if.slave bus
);

   localparam int unsigned CNT_W    = (DISP_CYCLES > 1) ? $clog2(DISP_CYCLES) : 1;
   localparam logic [3:0]  PRICE_C  = 4'(PRICE);
   localparam logic [3:0]  MAX_C    = 4'(MAX_CREDIT);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DISP_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      DISPENSE = 2'd1,
      REFUND   = 2'd2
   } state_t;

   state_t           state;
   logic [3:0]       credit;
   logic [CNT_W-1:0] cnt;
   logic             dispense;
   logic             refund;
   logic             reject;
   logic             busy;

   logic coin, sel, cancel;
   assign coin   = ~bus.i_coin_n;
   assign sel    = ~bus.i_sel_n;
   assign cancel = ~bus.i_cancel_n;

   // Main FSM: state, credit, dispense counter and all registered outputs.
   // IDLE priority cascades cancel > select > coin; an event that is ignored
   // (cancel at zero credit, unaffordable/empty select) lets the next one through.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state    <= IDLE;
         credit   <= '0;
         cnt      <= '0;
         dispense <= 1'b0;
         refund   <= 1'b0;
         reject   <= 1'b0;
         busy     <= 1'b0;
      end else begin
         reject <= 1'b0;
         refund <= 1'b0;
         unique case (state)
            IDLE: begin
               if (cancel && credit != '0) begin
                  state  <= REFUND;
                  busy   <= 1'b1;
                  reject <= coin;
               end else if (sel && credit >= PRICE_C && !bus.i_empty) begin
                  state    <= DISPENSE;
                  busy     <= 1'b1;
                  dispense <= 1'b1;
                  cnt      <= CNT_LOAD;
                  credit   <= credit - PRICE_C;
                  reject   <= coin;
               end else if (coin) begin
                  if (credit < MAX_C)
                     credit <= credit + 4'd1;
                  else
                     reject <= 1'b1;
               end
            end
            DISPENSE: begin
               reject <= coin;
               if (cnt == '0) begin
                  dispense <= 1'b0;
                  if (credit != '0) begin
                     state <= REFUND;
                  end else begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            REFUND: begin
               reject <= coin;
               if (credit != '0) begin
                  refund <= 1'b1;
                  credit <= credit - 4'd1;
                  if (credit == 4'd1) begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end
               end else begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            default: begin
               state    <= IDLE;
               busy     <= 1'b0;
               dispense <= 1'b0;
            end
         endcase
      end
   end

   assign bus.o_credit   = credit;
   assign bus.o_dispense = dispense;
   assign bus.o_refund   = refund;
   assign bus.o_reject   = reject;
   assign bus.o_busy     = busy;

endmodule

// File: tb/tb_vend_ctrl.sv
// Directed bench for vend_ctrl with PRICE=3, MAX_CREDIT=9, DISP_CYCLES=4.
module tb_vend_ctrl;

   logic clk;
   logic rst;
   int   n_assert;
   int   n_fail;

   vend_ctrl_if bus ();

   vend_ctrl #(
      .PRICE       (3),
      .MAX_CREDIT  (9),
      .DISP_CYCLES (4)
   ) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic [3:0] c, input logic d,
                          input logic r, input logic j, input logic b);
      check({tag, "/credit"},   bus.o_credit,           c);
      check({tag, "/dispense"}, {3'b0, bus.o_dispense}, {3'b0, d});
      check({tag, "/refund"},   {3'b0, bus.o_refund},   {3'b0, r});
      check({tag, "/reject"},   {3'b0, bus.o_reject},   {3'b0, j});
      check({tag, "/busy"},     {3'b0, bus.o_busy},     {3'b0, b});
   endtask

   // One clock with the given pulses sampled at the rising edge; returns #1 after it.
   task automatic step(input logic coin, input logic sel, input logic cancel);
      @(negedge clk);
      bus.i_coin_n   = ~coin;
      bus.i_sel_n    = ~sel;
      bus.i_cancel_n = ~cancel;
      @(posedge clk);
      #1;
      bus.i_coin_n   = 1'b1;
      bus.i_sel_n    = 1'b1;
      bus.i_cancel_n = 1'b1;
   endtask

   initial begin
      n_assert       = 0;
      n_fail         = 0;
      rst            = 1'b0;
      bus.i_coin_n   = 1'b1;
      bus.i_sel_n    = 1'b1;
      bus.i_cancel_n = 1'b1;
      bus.i_empty    = 1'b0;

      // Reset state
      repeat (3) @(posedge clk);
      #1 chk_out("reset", 4'd0, 0, 0, 0, 0);
      @(negedge clk) rst = 1'b1;

      // 3 coins then select: exact price, dispense 4 cycles, no refund
      step(1, 0, 0); chk_out("a_coin1", 4'd1, 0, 0, 0, 0);
      step(1, 0, 0); chk_out("a_coin2", 4'd2, 0, 0, 0, 0);
      step(1, 0, 0); chk_out("a_coin3", 4'd3, 0, 0, 0, 0);
      step(0, 1, 0); chk_out("a_sel",   4'd0, 1, 0, 0, 1);
      for (int i = 0; i < 3; i++) begin
         step(0, 0, 0); chk_out("a_disp", 4'd0, 1, 0, 0, 1);
      end
      step(0, 0, 0); chk_out("a_exit", 4'd0, 0, 0, 0, 0);

      // Cancel with zero credit is ignored
      step(0, 0, 1); chk_out("cancel0", 4'd0, 0, 0, 0, 0);

      // 5 coins then select: change refunded after dispense
      for (int i = 1; i <= 5; i++) step(1, 0, 0);
      chk_out("b_coins", 4'd5, 0, 0, 0, 0);
      step(0, 1, 0); chk_out("b_sel", 4'd2, 1, 0, 0, 1);
      for (int i = 0; i < 3; i++) begin
         step(0, 0, 0); chk_out("b_disp", 4'd2, 1, 0, 0, 1);
      end
      step(0, 0, 0); chk_out("b_to_refund", 4'd2, 0, 0, 0, 1);
      step(0, 0, 0); chk_out("b_ref1", 4'd1, 0, 1, 0, 1);
      step(0, 0, 0); chk_out("b_ref2", 4'd0, 0, 1, 0, 0);
      step(0, 0, 0); chk_out("b_idle", 4'd0, 0, 0, 0, 0);

      // Saturation at 9; 10th coin rejected
      for (int i = 1; i <= 9; i++) step(1, 0, 0);
      chk_out("c_nine", 4'd9, 0, 0, 0, 0);
      step(1, 0, 0); chk_out("c_sat", 4'd9, 0, 0, 1, 0);
      step(0, 0, 0); chk_out("c_rej_end", 4'd9, 0, 0, 0, 0);
      step(0, 0, 1); chk_out("c_cancel", 4'd9, 0, 0, 0, 1);
      for (int i = 8; i >= 0; i--) begin
         step(0, 0, 0); chk_out("c_ref", 4'(i), 0, 1, 0, (i != 0));
      end
      step(0, 0, 0); chk_out("c_idle", 4'd0, 0, 0, 0, 0);

      // 2 coins, select ignored, then cancel refunds 2
      step(1, 0, 0); step(1, 0, 0);
      step(0, 1, 0); chk_out("d_sel_ign", 4'd2, 0, 0, 0, 0);
      step(0, 0, 1); chk_out("d_cancel", 4'd2, 0, 0, 0, 1);
      step(0, 0, 0); chk_out("d_ref1", 4'd1, 0, 1, 0, 1);
      step(0, 0, 0); chk_out("d_ref2", 4'd0, 0, 1, 0, 0);
      step(0, 0, 0); chk_out("d_idle", 4'd0, 0, 0, 0, 0);

      // Select ignored while stock empty
      for (int i = 1; i <= 3; i++) step(1, 0, 0);
      bus.i_empty = 1'b1;
      step(0, 1, 0); chk_out("e_empty", 4'd3, 0, 0, 0, 0);
      bus.i_empty = 1'b0;

      // cancel+select+coin together: refund wins, coin rejected
      step(1, 0, 0); chk_out("f_four", 4'd4, 0, 0, 0, 0);
      step(1, 1, 1); chk_out("f_all", 4'd4, 0, 0, 1, 1);
      for (int i = 3; i >= 0; i--) begin
         step(0, 0, 0); chk_out("f_ref", 4'(i), 0, 1, 0, (i != 0));
      end
      step(0, 0, 0); chk_out("f_idle", 4'd0, 0, 0, 0, 0);

      // Coin during DISPENSE rejected, credit unchanged
      for (int i = 1; i <= 3; i++) step(1, 0, 0);
      step(0, 1, 0); chk_out("g_sel",  4'd0, 1, 0, 0, 1);
      step(1, 0, 0); chk_out("g_coin", 4'd0, 1, 0, 1, 1);
      step(0, 0, 0); chk_out("g_d3",   4'd0, 1, 0, 0, 1);
      step(0, 0, 0); chk_out("g_d4",   4'd0, 1, 0, 0, 1);
      step(0, 0, 0); chk_out("g_exit", 4'd0, 0, 0, 0, 0);

      // Reset during cycle 2 of DISPENSE aborts with no refund
      for (int i = 1; i <= 4; i++) step(1, 0, 0);
      step(0, 1, 0); chk_out("h_sel", 4'd1, 1, 0, 0, 1);
      step(0, 0, 0); chk_out("h_d2",  4'd1, 1, 0, 0, 1);
      @(negedge clk);
      rst = 1'b0;
      #1 chk_out("h_async", 4'd0, 0, 0, 0, 0);
      @(posedge clk);
      #1 chk_out("h_hold", 4'd0, 0, 0, 0, 0);
      @(negedge clk) rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1 chk_out("h_after", 4'd0, 0, 0, 0, 0);
      end

      // First pulse after reset release processed normally
      step(1, 0, 0); chk_out("i_first", 4'd1, 0, 0, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
